// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds the FSM state/owner enums and the round-robin pick helper.
package mem_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int ROM_RAM_SEL_BIT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // On a tie the requester that did not own the previous access wins.
  function automatic owner_t rr_pick(input logic req_if, input logic req_d, input owner_t last);
    owner_t w;
    if (req_if && req_d) begin
      w = (last == OWN_IF) ? OWN_D : OWN_IF;
    end else if (req_d) begin
      w = OWN_D;
    end else begin
      w = OWN_IF;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; grants only while enabled and remembers
// the last granted requester for tie breaking.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_en,
  input  logic   i_req_if,
  input  logic   i_req_d,
  output logic   o_gnt_if,
  output logic   o_gnt_d,
  output owner_t o_winner
);

  owner_t r_last;

  assign o_winner = rr_pick(i_req_if, i_req_d, r_last);

  // Grant decode for the current cycle.
  always_comb begin
    o_gnt_if = 1'b0;
    o_gnt_d  = 1'b0;
    if (i_en && (i_req_if || i_req_d)) begin
      if (o_winner == OWN_D) begin
        o_gnt_d = 1'b1;
      end else begin
        o_gnt_if = 1'b1;
      end
    end else begin
      o_gnt_if = 1'b0;
      o_gnt_d  = 1'b0;
    end
  end

  // Last-owner register; starts at IF so D wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= OWN_IF;
    end else if (o_gnt_d) begin
      r_last <= OWN_D;
    end else if (o_gnt_if) begin
      r_last <= OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single Memory between the fetch (IF) and load/store (D) ports.
// Optional feature macro MEM_ARB_ROM_WRITE_GUARD_EN: suppress D writes to ROM and report d_err.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_readWrite,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              busy
);

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_winner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_d_rdata;
  logic [2:0]        r_lat_cnt;
  logic              r_we, r_guard;
  logic              w_arb_en, w_gnt_if, w_gnt_d, w_grant, w_rom_wr;

  // Gating with reset keeps every output low while reset is held.
  assign w_arb_en = (r_state == IDLE) & ~reset;

  rr_arbiter2 u_rr (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_en     (w_arb_en),
    .i_req_if (if_req),
    .i_req_d  (d_req),
    .o_gnt_if (w_gnt_if),
    .o_gnt_d  (w_gnt_d),
    .o_winner (w_winner)
  );

  assign w_grant = w_gnt_if | w_gnt_d;

`ifdef MEM_ARB_ROM_WRITE_GUARD_EN
  assign w_rom_wr = w_gnt_d & d_we & ~d_addr[ROM_RAM_SEL_BIT];
`else
  assign w_rom_wr = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (MEM_LATENCY > 1) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = RESP;
        end
      end
      WAIT: begin
        if (r_lat_cnt == 3'd1) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch, latency counter and per-port read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= OWN_IF;
      r_addr     <= {ADDR_W{1'b0}};
      r_we       <= 1'b0;
      r_wdata    <= {DATA_W{1'b0}};
      r_guard    <= 1'b0;
      r_lat_cnt  <= 3'd0;
      r_if_rdata <= {DATA_W{1'b0}};
      r_d_rdata  <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_guard <= w_rom_wr;
            if (w_gnt_d) begin
              r_addr  <= d_addr;
              r_we    <= d_we;
              r_wdata <= d_wdata;
            end else begin
              r_addr  <= if_addr;
              r_we    <= 1'b0;
              r_wdata <= {DATA_W{1'b0}};
            end
          end
        end
        ACCESS: r_lat_cnt <= 3'(MEM_LATENCY - 1);
        WAIT:   r_lat_cnt <= r_lat_cnt - 3'd1;
        RESP: begin
          if (r_owner == OWN_IF) begin
            r_if_rdata <= mem_dataOut;
          end else if (!r_guard) begin
            r_d_rdata <= mem_dataOut;
          end
        end
        default: r_lat_cnt <= 3'd0;
      endcase
    end
  end

  assign if_gnt        = w_gnt_if;
  assign d_gnt         = w_gnt_d;
  assign busy          = (r_state != IDLE);
  assign mem_address   = busy ? r_addr : {ADDR_W{1'b0}};
  assign mem_dataIn    = busy ? r_wdata : {DATA_W{1'b0}};
  // Write strobe only in ACCESS so a write lands exactly once.
  assign mem_readWrite = (r_state == ACCESS) & r_we & ~r_guard;
  assign if_rvalid     = (r_state == RESP) & (r_owner == OWN_IF);
  assign d_rvalid      = (r_state == RESP) & (r_owner == OWN_D);
  // Read data is presented in the RESP cycle itself, then held from the capture register.
  assign if_rdata      = if_rvalid ? mem_dataOut : r_if_rdata;
  assign d_rdata       = (d_rvalid & ~r_guard) ? mem_dataOut : r_d_rdata;
  assign d_err         = d_rvalid & r_guard;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (MEM_LATENCY 1 and 3), each with its own
// Memory model and a transaction-level reference model compared every cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  logic        reset [2];
  logic        if_req [2];
  logic [31:0] if_addr [2];
  logic        if_gnt [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        d_gnt [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata [2];
  logic        d_err [2];
  logic [31:0] mem_address [2];
  logic        mem_readWrite [2];
  logic [31:0] mem_dataIn [2];
  logic [31:0] mem_dataOut [2];
  logic        busy [2];

  int          g_cyc [2][8];
  logic        g_own [2][8];
  int          g_n [2];
  int          rv_cyc [2];
  logic [31:0] rv_data [2];
  logic        rv_err [2];
  int          rw_cnt [2];
  int          busy_n [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int k, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %h expected %h (cycle %0d)", k, nm, got, exp, cyc);
    end
  endtask

  task automatic chk1(input int k, input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %b expected %b (cycle %0d)", k, nm, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]), .d_err(d_err[g]),
      .mem_address(mem_address[g]), .mem_readWrite(mem_readWrite[g]),
      .mem_dataIn(mem_dataIn[g]), .mem_dataOut(mem_dataOut[g]), .busy(busy[g])
    );

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] pipe [LAT];

    initial begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]     = 32'hC0DE_0000 | 32'(i);
        ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      end
      for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
    end

    // Memory: registered read of LAT edges, write on readWrite.
    always @(posedge clk) begin
      pipe[0] <= mem[mem_address[g][11:2]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (mem_readWrite[g]) mem[mem_address[g][11:2]] <= mem_dataIn[g];
    end
    assign mem_dataOut[g] = pipe[LAT-1];

    // Reference model: t counts cycles since the grant of the current access.
    logic        act = 1'b0, own = 1'b0, last = 1'b0, m_we = 1'b0, m_guard = 1'b0;
    int          t = 0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rd = 32'h0, ird = 32'h0, drd = 32'h0;

    always @(negedge clk) begin
      logic e_ig, e_dg, e_iv, e_dv, e_rw, e_busy, e_err, d_wins;
      logic [31:0] e_addr, e_din;
      e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_rw = 1'b0;
      e_busy = 1'b0; e_err = 1'b0; e_addr = 32'h0; e_din = 32'h0;
      if (reset[g]) begin
        act = 1'b0; last = 1'b0; ird = 32'h0; drd = 32'h0;
      end else if (act) begin
        e_busy = 1'b1; e_addr = m_addr; e_din = m_wdata;
        e_rw = (t == 1) && m_we && !m_guard;
        if (t == LAT + 1) begin
          act = 1'b0;
          if (own) begin
            e_dv = 1'b1; e_err = m_guard;
            if (!m_guard) drd = m_rd;
          end else begin
            e_iv = 1'b1; ird = m_rd;
          end
        end else begin
          t = t + 1;
        end
      end else if (if_req[g] || d_req[g]) begin
        d_wins = d_req[g] && (!if_req[g] || !last);
        own = d_wins; last = d_wins; act = 1'b1; t = 1;
        e_ig = !d_wins; e_dg = d_wins;
        m_addr  = d_wins ? d_addr[g] : if_addr[g];
        m_we    = d_wins && d_we[g];
        m_wdata = d_wins ? d_wdata[g] : 32'h0;
`ifdef MEM_ARB_ROM_WRITE_GUARD_EN
        m_guard = m_we && !m_addr[10];
`else
        m_guard = 1'b0;
`endif
        m_rd = ref_mem[m_addr[11:2]];
        if (m_we && !m_guard) ref_mem[m_addr[11:2]] = m_wdata;
      end
      chk1(g, "if_gnt", if_gnt[g], e_ig);
      chk1(g, "d_gnt", d_gnt[g], e_dg);
      chk1(g, "if_rvalid", if_rvalid[g], e_iv);
      chk1(g, "d_rvalid", d_rvalid[g], e_dv);
      chk1(g, "d_err", d_err[g], e_err);
      chk1(g, "busy", busy[g], e_busy);
      chk1(g, "mem_readWrite", mem_readWrite[g], e_rw);
      chk(g, "mem_address", mem_address[g], e_addr);
      chk(g, "mem_dataIn", mem_dataIn[g], e_din);
      chk(g, "if_rdata", if_rdata[g], ird);
      chk(g, "d_rdata", d_rdata[g], drd);
      if (if_gnt[g] || d_gnt[g]) begin
        if (g_n[g] < 8) begin
          g_cyc[g][g_n[g]] = cyc;
          g_own[g][g_n[g]] = d_gnt[g];
        end
        g_n[g]++;
      end
      if (if_rvalid[g] || d_rvalid[g]) begin
        rv_cyc[g]  = cyc;
        rv_data[g] = if_rvalid[g] ? if_rdata[g] : d_rdata[g];
        rv_err[g]  = d_err[g];
      end
      if (mem_readWrite[g]) rw_cnt[g]++;
      if (busy[g]) busy_n[g]++;
    end
  end

  task automatic clr(input int k);
    g_n[k] = 0; rw_cnt[k] = 0; busy_n[k] = 0; rv_cyc[k] = -1;
    rv_data[k] = 32'h0; rv_err[k] = 1'b0;
  endtask

  task automatic wait_gnt(input int k, input logic is_d);
    int n; logic got;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = is_d ? d_gnt[k] : if_gnt[k];
    end
    chk1(k, "gnt_seen", got, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rv(input int k);
    int n; logic got;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = if_rvalid[k] || d_rvalid[k];
    end
    chk1(k, "rvalid_seen", got, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int k, input logic [31:0] a);
    if_addr[k] = a; if_req[k] = 1'b1;
    wait_gnt(k, 1'b0);
    if_req[k] = 1'b0;
  endtask

  task automatic d_access(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; d_req[k] = 1'b1;
    wait_gnt(k, 1'b1);
    d_req[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = 32'h0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
      clr(k);
    end
    @(posedge clk); #1;
    if_req[0] = 1'b1;
    @(negedge clk);
    chk1(0, "reset_no_gnt", if_gnt[0], 1'b0);
    chk1(0, "reset_busy", busy[0], 1'b0);
    @(posedge clk); #1;
    if_req[0] = 1'b0; reset[0] = 1'b0; reset[1] = 1'b0;

    // Single fetch, latency 1.
    clr(0);
    fetch(0, 32'h0000_0010);
    wait_rv(0);
    chk(0, "fetch_gnt_count", g_n[0], 1);
    chk1(0, "fetch_owner_if", g_own[0][0], 1'b0);
    chk(0, "fetch_latency", rv_cyc[0] - g_cyc[0][0], 2);
    chk(0, "fetch_data", rv_data[0], 32'hC0DE_0004);

    // Tie: grants alternate D, IF, D, IF, three cycles apart.
    clr(0);
    fork
      begin d_access(0, 1'b0, 32'h400, 32'h0); d_access(0, 1'b0, 32'h400, 32'h0); end
      begin fetch(0, 32'h20); fetch(0, 32'h20); end
    join
    wait_rv(0);
    chk(0, "tie_gnt_count", g_n[0], 4);
    for (int i = 0; i < 4; i++) chk1(0, "tie_order", g_own[0][i], (i % 2 == 0));
    for (int i = 0; i < 3; i++) chk(0, "tie_space", g_cyc[0][i+1] - g_cyc[0][i], 3);
    chk(0, "tie_last_data", rv_data[0], 32'hC0DE_0008);

    // RAM write then read back.
    clr(0);
    d_access(0, 1'b1, 32'h404, 32'hDEAD_BEEF);
    wait_rv(0);
    chk(0, "ram_wr_strobes", rw_cnt[0], 1);
    chk1(0, "ram_wr_err", rv_err[0], 1'b0);
    d_access(0, 1'b0, 32'h404, 32'h0);
    wait_rv(0);
    chk(0, "ram_rd_data", rv_data[0], 32'hDEAD_BEEF);

    // Write into the ROM region.
    clr(0);
    d_access(0, 1'b1, 32'h010, 32'h1234_5678);
    wait_rv(0);
`ifdef MEM_ARB_ROM_WRITE_GUARD_EN
    chk(0, "rom_wr_strobes", rw_cnt[0], 0);
    chk1(0, "rom_wr_err", rv_err[0], 1'b1);
`else
    chk(0, "rom_wr_strobes", rw_cnt[0], 1);
    chk1(0, "rom_wr_err", rv_err[0], 1'b0);
`endif
    d_access(0, 1'b0, 32'h010, 32'h0);
    wait_rv(0);
`ifdef MEM_ARB_ROM_WRITE_GUARD_EN
    chk(0, "rom_rd_data", rv_data[0], 32'hC0DE_0004);
`else
    chk(0, "rom_rd_data", rv_data[0], 32'h1234_5678);
`endif

    // Latency 3 fetch.
    clr(1);
    fetch(1, 32'h0000_0010);
    wait_rv(1);
    chk(1, "lat3_latency", rv_cyc[1] - g_cyc[1][0], 4);
    chk(1, "lat3_busy_cycles", busy_n[1], 4);
    chk(1, "lat3_data", rv_data[1], 32'hC0DE_0004);

    // Reset during WAIT with both requests pending.
    d_we[1] = 1'b1; d_addr[1] = 32'h408; d_wdata[1] = 32'h0BAD_F00D; d_req[1] = 1'b1;
    wait_gnt(1, 1'b1);
    d_req[1] = 1'b0;
    @(posedge clk); #1;
    d_we[1] = 1'b0; d_req[1] = 1'b1; if_addr[1] = 32'h30; if_req[1] = 1'b1;
    reset[1] = 1'b1;
    #1;
    chk1(1, "rst_busy", busy[1], 1'b0);
    chk1(1, "rst_readWrite", mem_readWrite[1], 1'b0);
    chk1(1, "rst_d_rvalid", d_rvalid[1], 1'b0);
    chk1(1, "rst_if_rvalid", if_rvalid[1], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    clr(1);
    reset[1] = 1'b0;
    wait_gnt(1, 1'b1);
    d_req[1] = 1'b0;
    chk1(1, "rst_first_owner_d", g_own[1][0], 1'b1);
    wait_rv(1);
    chk(1, "rst_d_data", rv_data[1], 32'h0BAD_F00D);
    wait_gnt(1, 1'b0);
    if_req[1] = 1'b0;
    wait_rv(1);
    chk(1, "rst_if_data", rv_data[1], 32'hC0DE_000C);
    chk(1, "rst_gnt_count", g_n[1], 2);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified Memory block between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Memory address map: ROM when address[10]==0, RAM when address[10]==1.
- The arbiter grants one requester at a time and drives the Memory address, readWrite and dataIn inputs.
- It waits the Memory's registered read latency, then returns dataOut to the granted requester with a one-cycle valid pulse.

Parameters:
- MEM_LATENCY, 1: clock edges from driving the Memory inputs until dataOut is valid. Legal range 1..7.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_gnt.
- if_addr  input  ADDR_W  fetch address; stable while if_req is high.
- if_gnt  output  1  one-cycle pulse: fetch request accepted.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DATA_W  fetch read data.
- d_req  input  1  data request; held high until d_gnt.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_gnt  output  1  one-cycle pulse: data request accepted.
- d_rvalid  output  1  one-cycle pulse: completion. Carries read data for reads; acknowledge only for writes.
- d_rdata  output  DATA_W  data read result.
- d_err  output  1  access fault, qualified by d_rvalid.
- mem_address  output  ADDR_W  to Memory address.
- mem_readWrite  output  1  to Memory readWrite.
- mem_dataIn  output  DATA_W  to Memory dataIn.
- mem_dataOut  input  DATA_W  from Memory dataOut.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (asynchronous):
  - All outputs 0; state IDLE; lat_cnt 0.
  - last_owner = IF, so D wins the first tie.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If only one request is high, grant it.
  - If both are high, grant the requester that is not last_owner (round-robin).
  - On a grant, in the same cycle:
    - pulse the corresponding gnt;
    - latch owner, address, we and wdata into registers;
    - update last_owner;
    - go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_address, mem_readWrite (= latched we, D only; IF always 0) and mem_dataIn are driven from the latched registers.
  - lat_cnt is loaded with MEM_LATENCY-1.
  - Go to WAIT if MEM_LATENCY>1, else go to RESP.
- WAIT:
  - Memory inputs held; mem_readWrite forced to 0 after the ACCESS cycle so a write occurs exactly once.
  - lat_cnt decrements each cycle; go to RESP when it reaches 0.
- RESP:
  - Capture mem_dataOut into the owner's rdata register and pulse the owner's rvalid for one cycle.
  - The other requester's rdata is unchanged.
  - Go to IDLE. A new grant is possible in the next cycle.
- Latency:
  - req seen in IDLE at cycle N → gnt at N → rvalid at N+1+MEM_LATENCY.
  - Throughput: one access per MEM_LATENCY+2 cycles.
- Requests that arrive while busy stay pending (requester holds req); they are never dropped.
- A req deasserted before its grant is treated as withdrawn; no response is produced.
- Writes to the ROM region are forwarded unchanged; the Memory ignores them.
- Simultaneous if_req and d_req in consecutive arbitrations strictly alternate.
- Reset asserted mid-transaction:
  - abort immediately, return to IDLE;
  - no rvalid is issued;
  - mem_readWrite drops to 0 asynchronously.
- Memory inputs are 0 in IDLE.

Optional Feature:
- Macro: MEM_ARB_ROM_WRITE_GUARD_EN.
- Defined:
  - A D write with d_addr[10]==0 is granted normally.
  - mem_readWrite stays 0 for the whole transaction.
  - In RESP, d_rvalid pulses with d_err=1 and d_rdata is unchanged.
  - All other accesses return d_err=0.
- Undefined:
  - d_err is tied to 0.
  - ROM writes are issued to the Memory as ordinary writes.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE/ACCESS/WAIT/RESP);
  - owner enum (OWN_IF/OWN_D);
  - constant ROM_RAM_SEL_BIT = 10;
  - DATA_W/ADDR_W defaults.
- One sub-module, rr_arbiter2: 2-way round-robin grant logic with a last_owner register and an enable. The FSM, latency counter and datapath registers stay in the top module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010, MEM_LATENCY=1 → if_gnt at cycle 0, mem_readWrite=0 at cycle 1, if_rvalid at cycle 2 with if_rdata = ROM word; d_rvalid stays 0.
- Tie after reset: if_req=d_req=1 held, d_we=0, d_addr=0x400 → grant order D, IF, D, IF; each rvalid carries the matching data; gnt pulses spaced 3 cycles apart.
- RAM write then read: d_we=1, d_addr=0x404, d_wdata=0xDEADBEEF → mem_readWrite=1 for exactly one cycle and d_rvalid pulses; then a read of 0x404 → d_rdata=0xDEADBEEF.
- Latency parameter: MEM_LATENCY=3, fetch at cycle 0 → if_rvalid at cycle 4; busy high from cycle 1 through cycle 4.
- Reset mid-op: assert reset in the WAIT state → busy, mem_readWrite and both rvalids go to 0 immediately; after release, a pending d_req is granted first.
- Guard (macro defined): d_we=1, d_addr=0x010 → mem_readWrite never 1; d_rvalid=1 with d_err=1. Macro undefined → mem_readWrite pulses 1 and d_err=0.
